// File: rtl/alu_seq_ctrl_pkg.sv
// Shared definitions for the stack-machine ALU and its sequencing controller:
// ALU op codes, controller command encodings, FSM states and per-command depth rules.
package definitions;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AOV = 3'd2;
  localparam logic [2:0] ALU_INC = 3'd3;
  localparam logic [2:0] ALU_ABS = 3'd4;
  localparam logic [2:0] ALU_AAS = 3'd5;
  localparam logic [2:0] ALU_BLT = 3'd6;
  localparam logic [2:0] ALU_CON = 3'd7;

  localparam logic [3:0] CMD_PUSH = 4'b1000;
  localparam logic [3:0] CMD_POP  = 4'b1001;
  localparam logic [3:0] CMD_LDA  = 4'b1010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } ctrl_state_t;

  function automatic logic cmd_is_reserved(input logic [3:0] c);
    return c[3] && (c != CMD_PUSH) && (c != CMD_POP) && (c != CMD_LDA);
  endfunction

  // Minimum stack occupancy a command needs; PUSH's upper bound is checked separately.
  function automatic int op_min_depth(input logic [3:0] c);
    int d;
    d = 0;
    if (!c[3]) begin
      case (c[2:0])
        ALU_INC: d = 0;
        ALU_ABS: d = 1;
        default: d = 2;
      endcase
    end else if (c == CMD_POP) begin
      d = 1;
    end
    return d;
  endfunction

endpackage

// File: rtl/alu_seq_ctrl_op_stack.sv
// Operand stack: register file plus occupancy counter, with top/next read ports
// and push, pop, write-top and write-next controls.
module op_stack
  import definitions::*;
#(
  parameter int DW          = 8,
  parameter int STACK_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         wr_top,
  input  logic                         wr_next,
  input  logic [DW-1:0]                push_data,
  input  logic [DW-1:0]                top_data,
  input  logic [DW-1:0]                next_data,
  output logic [DW-1:0]                top,
  output logic [DW-1:0]                next,
  output logic [$clog2(STACK_DEPTH):0] depth
);

  localparam int IW  = $clog2(STACK_DEPTH);
  localparam int DPW = IW + 1;

  logic [DPW-1:0] depth_q;
  logic [IW-1:0]  top_idx;
  logic [IW-1:0]  next_idx;
  logic [DW-1:0]  entry_rd [STACK_DEPTH];

  // Modulo-STACK_DEPTH indexing: a full stack (depth=STACK_DEPTH) maps back to the last slot.
  assign top_idx  = depth_q[IW-1:0] - IW'(1);
  assign next_idx = depth_q[IW-1:0] - IW'(2);

  generate
    for (genvar gi = 0; gi < STACK_DEPTH; gi++) begin : g_entry
      logic [DW-1:0] entry_q;

      always_ff @(posedge clk) begin
        if (reset) begin
          entry_q <= '0;
        end else if (push && (depth_q == DPW'(gi))) begin
          entry_q <= push_data;
        end else if (wr_top && (depth_q != '0) && (top_idx == IW'(gi))) begin
          entry_q <= top_data;
        end else if (wr_next && (depth_q > DPW'(1)) && (next_idx == IW'(gi))) begin
          entry_q <= next_data;
        end
      end

      assign entry_rd[gi] = entry_q;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      depth_q <= '0;
    end else if (push && !pop && (int'(depth_q) < STACK_DEPTH)) begin
      depth_q <= depth_q + DPW'(1);
    end else if (pop && !push && (depth_q != '0)) begin
      depth_q <= depth_q - DPW'(1);
    end
  end

  assign top   = (depth_q == '0)       ? '0 : entry_rd[top_idx];
  assign next  = (depth_q < DPW'(2))   ? '0 : entry_rd[next_idx];
  assign depth = depth_q;

endmodule

// File: rtl/alu_seq_ctrl.sv
// Sequencing controller for the 8-bit stack-machine ALU: accepts one command per
// handshake, drives the ALU for one EXEC cycle, writes results back and retires with done.
module alu_seq_ctrl
  import definitions::*;
#(
  parameter int DW          = 8,
  parameter int STACK_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [3:0]                   cmd,
  input  logic [DW-1:0]                imm,
  output logic [2:0]                   alu_op,
  output logic [DW-1:0]                alu_reg_val,
  output logic [DW-1:0]                alu_stack0,
  output logic [DW-1:0]                alu_stack1,
  input  logic [DW-1:0]                alu_reg_out,
  input  logic [DW-1:0]                alu_stack0_out,
  input  logic [DW-1:0]                alu_stack1_out,
  input  logic                         alu_branch,
  output logic                         done,
  output logic                         err,
  output logic                         branch_taken,
  output logic [DW-1:0]                acc,
  output logic [$clog2(STACK_DEPTH):0] depth
);

  ctrl_state_t   state_q;
  logic [3:0]    cmd_q;
  logic [DW-1:0] imm_q;
  logic [DW-1:0] acc_q;
  logic          branch_q;
  logic          done_q;
  logic          err_q;

  logic [$clog2(STACK_DEPTH):0] depth_w;
  logic [DW-1:0] top_w;
  logic [DW-1:0] next_w;

  logic exec_ok;
  logic stk_push;
  logic stk_pop;
  logic stk_wr_top;
  logic stk_wr_next;

  op_stack #(
    .DW          (DW),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_op_stack (
    .clk       (clk),
    .reset     (reset),
    .push      (stk_push),
    .pop       (stk_pop),
    .wr_top    (stk_wr_top),
    .wr_next   (stk_wr_next),
    .push_data (imm_q),
    .top_data  (alu_stack0_out),
    .next_data (alu_stack1_out),
    .top       (top_w),
    .next      (next_w),
    .depth     (depth_w)
  );

  // A failed command must leave every piece of architectural state untouched.
  always_comb begin
    exec_ok = !cmd_is_reserved(cmd_q)
              && (int'(depth_w) >= op_min_depth(cmd_q))
              && !((cmd_q == CMD_PUSH) && (int'(depth_w) >= STACK_DEPTH));
  end

  always_comb begin
    stk_push    = 1'b0;
    stk_pop     = 1'b0;
    stk_wr_top  = 1'b0;
    stk_wr_next = 1'b0;
    if ((state_q == EXEC) && exec_ok) begin
      if (!cmd_q[3]) begin
        case (cmd_q[2:0])
          ALU_ABS: stk_wr_top = 1'b1;
          ALU_AAS: begin
            stk_wr_top  = 1'b1;
            stk_wr_next = 1'b1;
          end
          default: ;
        endcase
      end else begin
        stk_push = (cmd_q == CMD_PUSH);
        stk_pop  = (cmd_q == CMD_POP);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cmd_q    <= '0;
      imm_q    <= '0;
      acc_q    <= '0;
      branch_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            cmd_q   <= cmd;
            imm_q   <= imm;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          if (exec_ok) begin
            if (!cmd_q[3]) begin
              case (cmd_q[2:0])
                ALU_ADD, ALU_SUB, ALU_AOV, ALU_INC, ALU_ABS: acc_q <= alu_reg_out;
                ALU_BLT, ALU_CON:                            branch_q <= alu_branch;
                default: ;
              endcase
            end else if (cmd_q == CMD_LDA) begin
              acc_q <= imm_q;
            end
          end
          done_q  <= 1'b1;
          err_q   <= !exec_ok;
          state_q <= RESP;
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready    = (state_q == IDLE);
  assign alu_op       = cmd_q[2:0];
  assign alu_reg_val  = acc_q;
  assign alu_stack0   = top_w;
  assign alu_stack1   = next_w;
  assign done         = done_q;
  assign err          = err_q;
  assign branch_taken = branch_q;
  assign acc          = acc_q;
  assign depth        = depth_w;

endmodule

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
Operand-stack and sequencing controller for the 8-bit stack-machine ALU.
- Accepts one command per valid/ready handshake.
- Holds a small operand stack and the accumulator register.
- Drives ALU op and operands for one cycle, writes results back, and reports done, branch outcome and stack errors.
- Sits between the instruction decoder and the combinational ALU.

Parameters:
- DW, 8, datapath width; ALU is fixed at 8, so only 8 is legal.
- STACK_DEPTH, 4, number of operand stack entries; depth counter is clog2(STACK_DEPTH)+1 bits.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  controller can accept a command (high only in IDLE).
- cmd  in  4  command: cmd[3]=0 is ALU op cmd[2:0]; 4'b1000 PUSH, 4'b1001 POP, 4'b1010 LDA; others reserved.
- imm  in  DW  immediate for PUSH/LDA, sampled at the handshake.
- alu_op  out  3  ALU op select.
- alu_reg_val  out  DW  accumulator value.
- alu_stack0  out  DW  stack top.
- alu_stack1  out  DW  stack next.
- alu_reg_out  in  DW  ALU result toward the accumulator.
- alu_stack0_out  in  DW  ALU result toward the top.
- alu_stack1_out  in  DW  ALU result toward next.
- alu_branch  in  1  ALU branch flag.
- done  out  1  one-cycle pulse, command retired.
- err  out  1  one-cycle pulse with done; stack under/overflow, or reserved cmd.
- branch_taken  out  1  last BLT/CON result, held until the next BLT/CON.
- acc  out  DW  accumulator.
- depth  out  3  current stack occupancy, 0..4.

Behaviour:
Reset values:
- State IDLE; acc, depth, all stack entries, latched cmd/imm, branch_taken, done, err are all 0.
- Reset wins over any in-flight command, which is discarded with no done.

Operand outputs:
- alu_stack0 = entry[depth-1], or 0 if depth=0.
- alu_stack1 = entry[depth-2], or 0 if depth<2.
- alu_reg_val = acc.
- alu_op = latched cmd[2:0].

FSM: IDLE -> EXEC -> RESP -> IDLE; 3 cycles per command.
- IDLE: cmd_ready=1; on cmd_valid&&cmd_ready, latch cmd/imm and go to EXEC.
- EXEC: ALU settles combinationally; at the end of the cycle write back per the table below, or flag an error, then go to RESP.
- RESP: done=1, err=1 if flagged; go to IDLE.
- Latency: handshake at edge E0, results visible after E1, done high in the cycle after E1.

Write-back table (stack0 = top, stack1 = next):
- ADD, SUB, AOV: need depth>=2; acc <= alu_reg_out; stack unchanged.
- INC: no depth requirement; acc <= alu_reg_out.
- ABS: needs depth>=1; acc <= alu_reg_out; top <= alu_stack0_out.
- AAS: needs depth>=2; top <= alu_stack0_out; next <= alu_stack1_out.
- BLT, CON: need depth>=2; branch_taken <= alu_branch.
- PUSH: needs depth<STACK_DEPTH; entry[depth] <= imm; depth+1.
- POP: needs depth>=1; depth-1; the popped entry is not cleared.
- LDA: acc <= imm.

Error rules:
- A depth violation or reserved cmd sets err.
- No acc, stack, depth or branch_taken change.
- The command still retires with done.
- No wrap-around: PUSH on full and POP on empty are errors, never wraps.
- cmd_valid outside IDLE is ignored; the producer must hold it until cmd_ready.

Decomposition:
- Shared package "definitions": add the cmd encodings CMD_PUSH, CMD_POP, CMD_LDA, the ctrl_state_t enum (IDLE, EXEC, RESP), and a per-op minimum-depth function next to the existing ALU op constants.
- One natural sub-module: op_stack, holding the register file, depth counter and top/next read ports, with push/pop/write-top/write-next controls.
- The FSM and write-back mux stay in alu_seq_ctrl.
- Bench instantiates the real Alu.

Test Plan:
- PUSH 0x30, PUSH 0x25, ADD -> acc=0x55, depth=2, done pulses 2 cycles after each accept, err=0.
- PUSH 0x10, PUSH 0x05, BLT -> branch_taken=1 (0x05<0x10); then PUSH 0x20, BLT -> branch_taken=0, held through a following INC.
- LDA 0xF6, PUSH 0x00, ABS -> acc=0x0A, top=0x0A, depth=1.
- After reset, ADD -> done=1, err=1, acc=0x00, depth=0; POP -> err=1, depth stays 0.
- PUSH 0x01..0x05 -> fifth PUSH gives err=1, depth=4, top=0x04.
- Reset asserted during EXEC of PUSH 0x77 -> no done, depth=0, acc=0, cmd_ready=1 the cycle after reset deasserts.
